// File: rtl/life_pkg.sv
// Shared types and B3/S23 rule constants for the Game-of-Life engine.
package life_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Birth needs exactly BIRTH_N neighbours; survival needs SURV_LO..SURV_HI.
    localparam int BIRTH_N = 3;
    localparam int SURV_LO = 2;
    localparam int SURV_HI = 3;

endpackage

// File: rtl/life_gen_if.sv
// Control/status bundle between the grid loader, life_gen and the readout logic.
interface life_gen_if #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int CNT_W = 16
);
    localparam int CELLS = ROWS * COLS;
    localparam int POP_W = $clog2(CELLS + 1);

    logic             clear;
    logic             load;
    logic             start;
    logic             pause;
    logic             stop_on_still;
    logic [CNT_W-1:0] steps;
    logic [CELLS-1:0] grid_in;
    logic [CELLS-1:0] grid_out;
    logic             busy;
    logic             done;
    logic             still;
    logic [CNT_W-1:0] gen_count;
    logic [POP_W-1:0] pop_count;

    modport master (
        output clear, load, start, pause, stop_on_still, steps, grid_in,
        input  grid_out, busy, done, still, gen_count, pop_count
    );

    modport slave (
        input  clear, load, start, pause, stop_on_still, steps, grid_in,
        output grid_out, busy, done, still, gen_count, pop_count
    );
endinterface

// File: rtl/life_cell.sv
// Next-state logic for a single cell from its eight neighbours.
module life_cell
    import life_pkg::*;
(
    input  logic [7:0] nbr_i,
    input  logic       cur_i,
    output logic       nxt_o
);
    logic [3:0] cnt;

    // Count live neighbours, then apply birth/survival.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(nbr_i[i]);
        end
        nxt_o = (cnt == 4'(BIRTH_N)) ||
                (cur_i && (cnt >= 4'(SURV_LO)) && (cnt <= 4'(SURV_HI)));
    end
endmodule

// File: rtl/life_gen.sv
// Game-of-Life generation engine: one generation per clock over a ROWS x COLS grid.
module life_gen
    import life_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int WRAP  = 0,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    life_gen_if.slave  bus
);
    localparam int CELLS = ROWS * COLS;
    localparam int POP_W = $clog2(CELLS + 1);

    state_t           state_q, state_d;
    logic [CELLS-1:0] grid_q, grid_d, grid_nxt;
    logic [CNT_W-1:0] gen_q, gen_d, rem_q, rem_d;
    logic             still_q, still_d, done_q, done_d;
    logic [POP_W-1:0] pop;

    // Per-cell neighbour gathering; off-grid neighbours are either wrapped or tied dead.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic [7:0] nbr;
            for (genvar gk = 0; gk < 8; gk++) begin : g_nbr
                localparam int  DR     = (gk < 3) ? -1 : ((gk < 5) ? 0 : 1);
                localparam int  DC     = (gk == 0 || gk == 3 || gk == 5) ? -1 :
                                         ((gk == 1 || gk == 6) ? 0 : 1);
                localparam int  RR     = gi + DR;
                localparam int  CC     = gj + DC;
                localparam bit  INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                localparam int  RW     = (RR + ROWS) % ROWS;
                localparam int  CW     = (CC + COLS) % COLS;
                if (WRAP != 0 || INSIDE) begin : g_live
                    assign nbr[gk] = grid_q[RW*COLS + CW];
                end else begin : g_dead
                    assign nbr[gk] = 1'b0;
                end
            end
            life_cell u_cell (
                .nbr_i (nbr),
                .cur_i (grid_q[gi*COLS + gj]),
                .nxt_o (grid_nxt[gi*COLS + gj])
            );
        end
    end

    // Population of the visible grid, zero latency from grid_out.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CELLS; i++) begin
            pop = pop + POP_W'(grid_q[i]);
        end
    end

    // Next-state decode: clear > load > start > run step.
    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        gen_d   = gen_q;
        rem_d   = rem_q;
        still_d = still_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            grid_d  = '0;
            gen_d   = '0;
            rem_d   = '0;
            still_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.load) begin
                grid_d  = bus.grid_in;
                gen_d   = '0;
                still_d = 1'b0;
            end else if (bus.start) begin
                still_d = 1'b0;
                if (bus.steps == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = RUN;
                    rem_d   = bus.steps;
                end
            end
        end else if (!bus.pause) begin
            gen_d = gen_q + CNT_W'(1);
            if (bus.stop_on_still && (grid_nxt == grid_q)) begin
                // Still life: the generation is counted but the run ends here.
                state_d = IDLE;
                done_d  = 1'b1;
                still_d = 1'b1;
            end else begin
                grid_d = grid_nxt;
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grid_q  <= '0;
            gen_q   <= '0;
            rem_q   <= '0;
            still_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            gen_q   <= gen_d;
            rem_q   <= rem_d;
            still_q <= still_d;
            done_q  <= done_d;
        end
    end

    assign bus.grid_out  = grid_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.still     = still_q;
    assign bus.gen_count = gen_q;
    assign bus.pop_count = pop;
endmodule

// File: tb/tb_life_gen.sv
// Self-checking bench: two engines (dead edge and toroidal) against a grid-level model.
module tb_life_gen;
    localparam int R  = 16;
    localparam int C  = 16;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         reset, clear, load, start, pause, sos;
    logic [15:0]  steps;
    logic [255:0] grid_in;
    bit           chk_en = 1'b0;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    life_gen_if #(.ROWS(R), .COLS(C), .CNT_W(CW)) bus0 ();
    life_gen_if #(.ROWS(R), .COLS(C), .CNT_W(CW)) bus1 ();

    assign bus0.clear = clear;  assign bus1.clear = clear;
    assign bus0.load  = load;   assign bus1.load  = load;
    assign bus0.start = start;  assign bus1.start = start;
    assign bus0.pause = pause;  assign bus1.pause = pause;
    assign bus0.stop_on_still = sos; assign bus1.stop_on_still = sos;
    assign bus0.steps   = steps;   assign bus1.steps   = steps;
    assign bus0.grid_in = grid_in; assign bus1.grid_in = grid_in;

    life_gen #(.ROWS(R), .COLS(C), .WRAP(0), .CNT_W(CW)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    life_gen #(.ROWS(R), .COLS(C), .WRAP(1), .CNT_W(CW)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // ---------------- reference model ----------------
    function automatic logic [255:0] life_next(input logic [255:0] g, input bit wrap);
        logic [255:0] res;
        int n, rr, cc;
        res = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + R) % R;
                            cc = (cc + C) % C;
                        end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
                            continue;
                        end
                        n += int'(g[rr*C + cc]);
                    end
                end
                res[r*C + c] = (n == 3) || (g[r*C + c] && n == 2);
            end
        end
        return res;
    endfunction

    logic [255:0] m_grid [2];
    logic         m_busy [2];
    logic         m_done [2];
    logic         m_still[2];
    logic [15:0]  m_gen  [2];
    logic [15:0]  m_rem  [2];

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            m_done[w] <= 1'b0;
            if (reset || clear) begin
                m_grid[w] <= '0; m_busy[w] <= 1'b0; m_still[w] <= 1'b0;
                m_gen[w]  <= '0; m_rem[w]  <= '0;
            end else if (!m_busy[w]) begin
                if (load) begin
                    m_grid[w] <= grid_in; m_gen[w] <= '0; m_still[w] <= 1'b0;
                end else if (start) begin
                    m_still[w] <= 1'b0;
                    if (steps == 16'd0) m_done[w] <= 1'b1;
                    else begin m_busy[w] <= 1'b1; m_rem[w] <= steps; end
                end
            end else if (!pause) begin
                m_gen[w] <= m_gen[w] + 16'd1;
                if (sos && life_next(m_grid[w], w == 1) == m_grid[w]) begin
                    m_busy[w] <= 1'b0; m_done[w] <= 1'b1; m_still[w] <= 1'b1;
                end else begin
                    m_grid[w] <= life_next(m_grid[w], w == 1);
                    m_rem[w]  <= m_rem[w] - 16'd1;
                    if (m_rem[w] == 16'd1) begin m_busy[w] <= 1'b0; m_done[w] <= 1'b1; end
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both engines against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("grid_w0",  bus0.grid_out, m_grid[0]);
            cmp("busy_w0",  256'(bus0.busy), 256'(m_busy[0]));
            cmp("done_w0",  256'(bus0.done), 256'(m_done[0]));
            cmp("still_w0", 256'(bus0.still), 256'(m_still[0]));
            cmp("gen_w0",   256'(bus0.gen_count), 256'(m_gen[0]));
            cmp("pop_w0",   256'(bus0.pop_count), 256'($countones(m_grid[0])));
            cmp("grid_w1",  bus1.grid_out, m_grid[1]);
            cmp("busy_w1",  256'(bus1.busy), 256'(m_busy[1]));
            cmp("done_w1",  256'(bus1.done), 256'(m_done[1]));
            cmp("still_w1", 256'(bus1.still), 256'(m_still[1]));
            cmp("gen_w1",   256'(bus1.gen_count), 256'(m_gen[1]));
            cmp("pop_w1",   256'(bus1.pop_count), 256'($countones(m_grid[1])));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input logic [255:0] g);
        @(negedge clk); load = 1'b1; grid_in = g;
        @(negedge clk); load = 1'b0;
    endtask

    // Wait for done on the dead-edge engine; cnt counts edges from the start edge.
    task automatic wait_done(inout int cnt);
        while (!bus0.done && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        if (!bus0.done) cmp("done_timeout", 256'(0), 256'(1));
    endtask

    // Start a run, optionally pausing (with an ignored load) right after the start edge.
    task automatic start_wait(input int n, input logic s, input int pause_cyc, output int cnt);
        @(negedge clk); start = 1'b1; steps = 16'(n); sos = s;
        @(negedge clk); start = 1'b0;
        cnt = 1;
        if (pause_cyc > 0) begin
            pause = 1'b1; load = 1'b1; grid_in = '1;
            repeat (pause_cyc) begin @(negedge clk); cnt++; end
            pause = 1'b0; load = 1'b0;
        end
        wait_done(cnt);
    endtask

    initial begin
        logic [255:0] g, blink_h, blink_v, glider, block;
        int cnt, guard, n;
        bit saw;

        reset = 1'b1; clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        sos = 1'b0; steps = '0; grid_in = '0;
        blink_h = '0; blink_h[7*16+6] = 1'b1; blink_h[7*16+7] = 1'b1; blink_h[7*16+8] = 1'b1;
        blink_v = '0; blink_v[6*16+7] = 1'b1; blink_v[7*16+7] = 1'b1; blink_v[8*16+7] = 1'b1;
        glider  = '0; glider[1] = 1'b1; glider[16+2] = 1'b1;
        glider[32] = 1'b1; glider[33] = 1'b1; glider[34] = 1'b1;
        block   = '0; block[7*16+7] = 1'b1; block[7*16+8] = 1'b1;
        block[8*16+7] = 1'b1; block[8*16+8] = 1'b1;

        @(negedge clk); chk_en = 1'b1;
        @(negedge clk); reset = 1'b0;
        cmp("rst_grid",  bus0.grid_out, '0);
        cmp("rst_busy",  256'(bus0.busy), 256'(0));
        cmp("rst_done",  256'(bus0.done), 256'(0));
        cmp("rst_still", 256'(bus0.still), 256'(0));
        cmp("rst_gen",   256'(bus0.gen_count), 256'(0));
        cmp("rst_pop",   256'(bus1.pop_count), 256'(0));
        $display("txn reset: outputs idle");

        start_wait(5, 1'b0, 0, cnt);
        cmp("empty_latency", 256'(cnt), 256'(6));
        cmp("empty_gen", 256'(bus0.gen_count), 256'(5));
        cmp("empty_grid", bus0.grid_out, '0);
        $display("txn empty run: latency=%0d gen=%0d", cnt, bus0.gen_count);

        g = '0; g[255:240] = 16'hFFFF;
        do_load(g);
        start_wait(1, 1'b0, 0, cnt);
        g = bus0.grid_out;
        cmp("row_latency", 256'(cnt), 256'(2));
        cmp("row15", 256'(g[255:240]), 256'(16'h7FFE));
        cmp("row14", 256'(g[239:224]), 256'(16'h7FFE));
        cmp("row_pop_w0", 256'(bus0.pop_count), 256'(28));
        cmp("row_pop_w1", 256'(bus1.pop_count), 256'(48));
        $display("txn full row: pop0=%0d pop1=%0d", bus0.pop_count, bus1.pop_count);

        do_load(blink_h);
        start_wait(3, 1'b0, 0, cnt);
        cmp("blink_grid", bus0.grid_out, blink_v);
        cmp("blink_gen", 256'(bus0.gen_count), 256'(3));
        cmp("blink_pop", 256'(bus0.pop_count), 256'(3));
        $display("txn blinker: latency=%0d", cnt);

        // Restart in the very cycle done is high.
        start = 1'b1; steps = 16'd2;
        @(negedge clk); start = 1'b0; cnt = 1;
        wait_done(cnt);
        cmp("restart_latency", 256'(cnt), 256'(3));
        cmp("restart_gen", 256'(bus0.gen_count), 256'(5));
        $display("txn restart on done: latency=%0d", cnt);

        do_load(glider);
        start_wait(64, 1'b0, 0, cnt);
        cmp("glider_wrap_grid", bus1.grid_out, glider);
        cmp("glider_gen", 256'(bus1.gen_count), 256'(64));
        cmp("glider_latency", 256'(cnt), 256'(65));
        $display("txn glider: pop0=%0d pop1=%0d", bus0.pop_count, bus1.pop_count);

        do_load(block);
        start_wait(100, 1'b1, 0, cnt);
        cmp("still_latency", 256'(cnt), 256'(2));
        cmp("still_flag", 256'(bus0.still), 256'(1));
        cmp("still_gen", 256'(bus0.gen_count), 256'(1));
        cmp("still_grid", bus0.grid_out, block);
        $display("txn still life: latency=%0d", cnt);

        do_load(blink_h);
        start_wait(10, 1'b0, 4, cnt);
        cmp("pause_latency", 256'(cnt), 256'(15));
        cmp("pause_grid", bus0.grid_out, blink_h);
        $display("txn paused blinker: latency=%0d", cnt);

        do_load(blink_h);
        @(negedge clk); start = 1'b1; steps = 16'd10; sos = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        cmp("clear_grid", bus0.grid_out, '0);
        cmp("clear_busy", 256'(bus0.busy), 256'(0));
        cmp("clear_gen", 256'(bus0.gen_count), 256'(0));
        saw = 1'b0;
        repeat (12) begin
            if (bus0.done) saw = 1'b1;
            @(negedge clk);
        end
        cmp("clear_no_done", 256'(saw), 256'(0));
        $display("txn clear mid-run");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) g[i*32 +: 32] = $urandom() & $urandom();
                do_load(g);
            end
            n = $urandom_range(0, 24);
            @(negedge clk); start = 1'b1; steps = 16'(n); sos = 1'($urandom_range(0, 1));
            @(negedge clk); start = 1'b0;
            guard = 0;
            while ((bus0.busy || bus1.busy) && guard < 2000) begin
                pause = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 60) == 0) clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                guard++;
            end
            pause = 1'b0;
            if (guard >= 2000) cmp("rand_timeout", 256'(0), 256'(1));
            $display("txn rand %0d: steps=%0d sos=%0d gen0=%0d gen1=%0d pop0=%0d pop1=%0d",
                     t, n, sos, bus0.gen_count, bus1.gen_count, bus0.pop_count, bus1.pop_count);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
